// File: rtl/imm_pack.sv
// imm_pack: packs a 64-bit immediate into a LEGv8 instruction template.
// It flags immediates that do not survive re-extension and counts delivered
// errored words (saturating). Two-stage valid/ready pipeline:
//   S1 = captured inputs, S2 = packed result.
module imm_pack #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      imm,
  input  logic [1:0]       ext,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             range_err,
  output logic [CNT_W-1:0] err_count
);

  logic        s1_valid;
  logic [63:0] s1_imm;
  logic [1:0]  s1_ext;
  logic [31:0] s1_base;

  logic        s2_load;
  logic        s1_accept;

  logic [31:0] pack_mask;
  logic [31:0] pack_field;
  logic [63:0] pack_back;
  logic [31:0] pack_instr;
  logic        pack_err;

  // S2 takes a new word (or a bubble) whenever it is empty or being drained.
  assign s2_load   = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign s1_accept = in_valid && in_ready;

  // Field placement and round-trip re-extension for the selected format.
  always_comb begin
    pack_mask  = 32'h0000_0000;
    pack_field = 32'h0000_0000;
    pack_back  = 64'h0;
    case (s1_ext)
      2'b00: begin
        pack_mask  = 32'h001F_F000;
        pack_field = {11'b0, s1_imm[8:0], 12'b0};
        pack_back  = {{55{s1_imm[8]}}, s1_imm[8:0]};
      end
      2'b01: begin
        pack_mask  = 32'h003F_FC00;
        pack_field = {10'b0, s1_imm[11:0], 10'b0};
        pack_back  = {52'b0, s1_imm[11:0]};
      end
      2'b10: begin
        pack_mask  = 32'h03FF_FFFF;
        pack_field = {6'b0, s1_imm[25:0]};
        pack_back  = {{38{s1_imm[25]}}, s1_imm[25:0]};
      end
      default: begin
        pack_mask  = 32'h00FF_FFE0;
        pack_field = {8'b0, s1_imm[18:0], 5'b0};
        pack_back  = {{45{s1_imm[18]}}, s1_imm[18:0]};
      end
    endcase
    pack_instr = (s1_base & ~pack_mask) | pack_field;
    pack_err   = (pack_back != s1_imm);
  end

  // S1: capture the upstream word on accept; empties when its word moves on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_imm   <= 64'h0;
      s1_ext   <= 2'b00;
      s1_base  <= 32'h0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_accept) begin
        s1_imm  <= imm;
        s1_ext  <= ext;
        s1_base <= base;
      end
    end
  end

  // S2: register the packed word; holds steady while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      instr     <= 32'h0;
      range_err <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instr     <= pack_instr;
        range_err <= pack_err;
      end
    end
  end

  // Saturating count of errored words actually handed downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (out_valid && out_ready && range_err && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: reference packing model plus scoreboard, checked on
// every falling edge, with directed literal expectations pinning the model.
module tb_imm_pack;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      imm;
  logic [1:0]       ext;
  logic [31:0]      base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             range_err;
  logic [CNT_W-1:0] err_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int          model_cnt = 0;
  int          n_out = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  imm_pack #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .ext(ext), .base(base), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .range_err(range_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {err, instr} from field width/position and numeric range.
  function automatic logic [32:0] ref_pack(input logic [63:0] v, input logic [1:0] e,
                                           input logic [31:0] b);
    int          w;
    int          lsb;
    bit          uns;
    logic [63:0] fmask;
    logic [63:0] fld;
    logic [31:0] m;
    longint      sv;
    longint      lo;
    longint      hi;
    bit          fits;
    case (e)
      2'd0:    begin w = 9;  lsb = 12; uns = 1'b0; end
      2'd1:    begin w = 12; lsb = 10; uns = 1'b1; end
      2'd2:    begin w = 26; lsb = 0;  uns = 1'b0; end
      default: begin w = 19; lsb = 5;  uns = 1'b0; end
    endcase
    fmask = (64'd1 << w) - 64'd1;
    fld   = v & fmask;
    m     = 32'(fmask << lsb);
    sv    = $signed(v);
    hi    = (longint'(1) << (w - 1)) - 1;
    lo    = -(longint'(1) << (w - 1));
    if (uns) fits = (v <= fmask);
    else     fits = (sv >= lo) && (sv <= hi);
    return {!fits, (b & ~m) | 32'(fld << lsb)};
  endfunction

  // Scoreboard / compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_err_count", 64'(err_count), 64'(0));
    end else begin
      check("err_count", 64'(err_count), 64'(model_cnt));
      check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
      if (prev_stall) begin
        check("stall_instr", 64'(instr), 64'(prev_instr));
        check("stall_err", 64'(range_err), 64'(prev_err));
        check("stall_valid", 64'(out_valid), 64'(1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: got instr %h with no word outstanding", instr);
        end else begin
          mon_e = exp_q.pop_front();
          check("instr", 64'(instr), 64'(mon_e[31:0]));
          check("range_err", 64'(range_err), 64'(mon_e[32]));
          n_out++;
          if (mon_e[32] && model_cnt < (2**CNT_W - 1)) model_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = instr;
      prev_err   = range_err;
      if (in_valid && in_ready) exp_q.push_back(ref_pack(imm, ext, base));
    end
  end

  task automatic send(input logic [63:0] i, input logic [1:0] e, input logic [31:0] b);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    imm = i;
    ext = e;
    base = b;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!ok && guard > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", guard);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [63:0] i, input logic [1:0] e, input logic [31:0] b,
                          input logic [31:0] exp_instr, input logic exp_err);
    send(i, e, b);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lit_instr", 64'(instr), 64'(exp_instr));
    check("lit_err", 64'(range_err), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r;
    int          n0;
    in_valid  = 1'b0;
    imm       = 64'h0;
    ext       = 2'b00;
    base      = 32'h0;
    out_ready = 1'b1;
    reset     = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_instr", 64'(instr), 64'(0));
    check("reset_range_err", 64'(range_err), 64'(0));
    check("reset_err_count", 64'(err_count), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Pin the reference model to hand-computed packings.
    check("model_d", 64'(ref_pack(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 32'hF840_0000)), 64'({1'b0, 32'hF85F_F000}));
    check("model_i", 64'(ref_pack(64'd4096, 2'b01, 32'h9100_0000)), 64'({1'b1, 32'h9100_0000}));
    check("model_cb", 64'(ref_pack(64'h4_0000, 2'b11, 32'hB400_0000)), 64'({1'b1, 32'hB480_0000}));

    // Directed format vectors.
    send_chk(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 32'hF840_0000, 32'hF85F_F000, 1'b0);
    send_chk(64'h0FFF, 2'b01, 32'h9100_0000, 32'h913F_FC00, 1'b0);
    send_chk(64'd4096, 2'b01, 32'h9100_0000, 32'h9100_0000, 1'b1);
    @(posedge clk); #1;
    check("err_count_one", 64'(err_count), 64'(1));
    send_chk(-64'sd4, 2'b10, 32'h1400_0000, 32'h17FF_FFFC, 1'b0);
    send_chk(64'h4_0000, 2'b11, 32'hB400_0000, 32'hB480_0000, 1'b1);
    send_chk(64'hFFFF_FFFF_FFFF_FF00, 2'b00, 32'h0, 32'h0010_0000, 1'b0);
    send_chk(64'h100, 2'b00, 32'h0, 32'h0010_0000, 1'b1);
    send_chk(64'h01FF_FFFF, 2'b10, 32'h0, 32'h01FF_FFFF, 1'b0);
    send_chk(64'h0200_0000, 2'b10, 32'hFFFF_FFFF, 32'hFE00_0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: three words against a stalled output.
    out_ready = 1'b0;
    send(64'd1, 2'b01, 32'h0);
    send(64'd2, 2'b01, 32'h0);
    in_valid = 1'b1;
    imm = 64'd3;
    ext = 2'b01;
    base = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_instr", 64'(instr), 64'(32'h0000_0400));
      check("bp_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out1", 64'(instr), 64'(32'h0000_0400));
    check("bp_ready_rel", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_out2_valid", 64'(out_valid), 64'(1));
    check("bp_out2", 64'(instr), 64'(32'h0000_0800));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_out3_valid", 64'(out_valid), 64'(1));
    check("bp_out3", 64'(instr), 64'(32'h0000_0C00));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

    // Streaming: one word per cycle with random formats and ranges.
    n0 = n_out;
    for (int k = 0; k < 20; k++) begin
      r = {$urandom, $urandom};
      imm = 64'($signed(r) >>> $urandom_range(63, 8));
      ext = 2'($urandom_range(3, 0));
      base = $urandom;
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", 64'(n_out - n0), 64'(20));

    // Saturation of the error counter.
    for (int k = 0; k < 260; k++) send(64'd4096, 2'b01, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("err_count_sat", 64'(err_count), 64'(255));

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(64'd5, 2'b01, 32'h0);
    send(64'd6, 2'b01, 32'h0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_count", 64'(err_count), 64'(0));
    check("mid_rst_instr", 64'(instr), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_valid", 64'(out_valid), 64'(0));
    end
    check("post_rst_none", 64'(n_out - n0), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
